// File: rtl/amiga_daug_dram_ctl.sv
// A1000 daughterboard DRAM sequencer: 68000 access vs RAS-only refresh, strobe generation.
// Optional build macro DAUG_WPRO_EN: writes with WPRO=1 are acknowledged but never reach the DRAM.
module amiga_daug_dram_ctl #(
  parameter int REF_INTERVAL = 108,
  parameter int T_RAS        = 2,
  parameter int T_CAS        = 2,
  parameter int T_RP         = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sel,
  input  logic       as_n,
  input  logic       uds_n,
  input  logic       lds_n,
  input  logic       prw_n,
  input  logic       wpro,
  output logic       ras_n,
  output logic       ucas_n,
  output logic       lcas_n,
  output logic       col,
  output logic       we_n,
  output logic       cdr_n,
  output logic       cdw_n,
  output logic       dae_n,
  output logic [7:0] ref_row,
  output logic       dtack_n,
  output logic       ref_miss
);

  localparam int TW = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
  localparam logic [TW-1:0] TIMER_MAX = TW'(REF_INTERVAL - 1);
  localparam logic [3:0] RAS_LAST = 4'(T_RAS - 1);
  localparam logic [3:0] CAS_LAST = 4'(T_CAS - 1);
  localparam logic [3:0] RP_LAST  = 4'(T_RP - 1);

  typedef enum logic [2:0] {IDLE, ROW, COLW, CAS, HOLD, PRE, RROW, RCAS} state_t;

  state_t        state_reg, state_next;
  logic [3:0]    cnt_reg, cnt_next;
  logic [TW-1:0] timer_reg;
  logic          ref_pend_reg, ref_miss_reg;
  logic [7:0]    ref_row_reg;
  logic          timer_wrap, ref_req, ref_done, wr_block;

  logic ras_reg, ucas_reg, lcas_reg, col_reg, we_reg, cdr_reg, cdw_reg, dae_reg, dtack_reg;
  logic ras_next, ucas_next, lcas_next, col_next, we_next, cdr_next, cdw_next, dae_next, dtack_next;

`ifdef DAUG_WPRO_EN
  assign wr_block = wpro && !prw_n;
`else
  logic wpro_unused;
  assign wpro_unused = wpro;
  assign wr_block    = 1'b0;
`endif

  assign timer_wrap = (timer_reg == TIMER_MAX);
  // A tick landing on the same edge as an access still wins the arbitration.
  assign ref_req    = ref_pend_reg || timer_wrap;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + 4'd1;
    ref_done   = 1'b0;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (ref_req)
          state_next = RROW;
        else if (sel && !as_n)
          state_next = ROW;
      end
      ROW: begin
        if (as_n) begin
          state_next = PRE;
          cnt_next   = '0;
        end else if (cnt_reg == RAS_LAST) begin
          state_next = prw_n ? CAS : COLW;
          cnt_next   = '0;
        end
      end
      COLW: begin
        cnt_next = '0;
        if (as_n)
          state_next = PRE;
        else if (!(uds_n && lds_n))
          state_next = CAS;
      end
      CAS: begin
        if (as_n) begin
          state_next = PRE;
          cnt_next   = '0;
        end else if (cnt_reg == CAS_LAST) begin
          state_next = HOLD;
          cnt_next   = '0;
        end
      end
      HOLD: begin
        cnt_next = '0;
        if (as_n)
          state_next = PRE;
      end
      PRE: begin
        if (cnt_reg == RP_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      end
      RROW: begin
        if (cnt_reg == RAS_LAST) begin
          state_next = RCAS;
          cnt_next   = '0;
        end
      end
      RCAS: begin
        if (cnt_reg == CAS_LAST) begin
          state_next = PRE;
          cnt_next   = '0;
          ref_done   = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase

    // Strobes are registered from the state being entered, so they switch cleanly on the edge.
    ras_next   = 1'b1;
    ucas_next  = 1'b1;
    lcas_next  = 1'b1;
    col_next   = 1'b0;
    we_next    = 1'b1;
    cdr_next   = 1'b1;
    cdw_next   = 1'b1;
    dae_next   = 1'b1;
    dtack_next = 1'b1;
    case (state_next)
      ROW: ras_next = 1'b0;
      COLW: begin
        ras_next = 1'b0;
        col_next = 1'b1;
      end
      CAS: begin
        ras_next = 1'b0;
        col_next = 1'b1;
        if (!wr_block) begin
          ucas_next = uds_n;
          lcas_next = lds_n;
          we_next   = prw_n;
          cdw_next  = prw_n;
          cdr_next  = !prw_n;
        end
      end
      HOLD: begin
        ras_next   = 1'b0;
        col_next   = 1'b1;
        ucas_next  = ucas_reg;
        lcas_next  = lcas_reg;
        we_next    = we_reg;
        cdr_next   = cdr_reg;
        cdw_next   = cdw_reg;
        dtack_next = 1'b0;
      end
      RROW, RCAS: begin
        ras_next = 1'b0;
        dae_next = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      timer_reg    <= '0;
      ref_pend_reg <= 1'b0;
      ref_miss_reg <= 1'b0;
      ref_row_reg  <= '0;
      ras_reg      <= 1'b1;
      ucas_reg     <= 1'b1;
      lcas_reg     <= 1'b1;
      col_reg      <= 1'b0;
      we_reg       <= 1'b1;
      cdr_reg      <= 1'b1;
      cdw_reg      <= 1'b1;
      dae_reg      <= 1'b1;
      dtack_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      timer_reg <= timer_wrap ? '0 : timer_reg + 1'b1;
      // A fresh tick outranks the clear from a refresh finishing on the same edge.
      if (timer_wrap) begin
        ref_pend_reg <= 1'b1;
        if (ref_pend_reg && !ref_done)
          ref_miss_reg <= 1'b1;
      end else if (ref_done) begin
        ref_pend_reg <= 1'b0;
      end
      if (ref_done)
        ref_row_reg <= ref_row_reg + 8'd1;
      ras_reg   <= ras_next;
      ucas_reg  <= ucas_next;
      lcas_reg  <= lcas_next;
      col_reg   <= col_next;
      we_reg    <= we_next;
      cdr_reg   <= cdr_next;
      cdw_reg   <= cdw_next;
      dae_reg   <= dae_next;
      dtack_reg <= dtack_next;
    end
  end

  assign ras_n    = ras_reg;
  assign ucas_n   = ucas_reg;
  assign lcas_n   = lcas_reg;
  assign col      = col_reg;
  assign we_n     = we_reg;
  assign cdr_n    = cdr_reg;
  assign cdw_n    = cdw_reg;
  assign dae_n    = dae_reg;
  assign dtack_n  = dtack_reg;
  assign ref_row  = ref_row_reg;
  assign ref_miss = ref_miss_reg;

endmodule

// File: tb/tb_amiga_daug_dram_ctl.sv
// Scoreboard bench for amiga_daug_dram_ctl: expected output vectors are queued per cycle and
// compared half a clock after each rising edge.
module tb_amiga_daug_dram_ctl;

  logic       clk = 1'b0;
  logic       rst, sel, as_n, uds_n, lds_n, prw_n, wpro;
  logic       ras_n, ucas_n, lcas_n, col, we_n, cdr_n, cdw_n, dae_n, dtack_n, ref_miss;
  logic [7:0] ref_row;

  amiga_daug_dram_ctl dut (
    .clk(clk), .rst(rst), .sel(sel), .as_n(as_n), .uds_n(uds_n), .lds_n(lds_n),
    .prw_n(prw_n), .wpro(wpro), .ras_n(ras_n), .ucas_n(ucas_n), .lcas_n(lcas_n),
    .col(col), .we_n(we_n), .cdr_n(cdr_n), .cdw_n(cdw_n), .dae_n(dae_n),
    .ref_row(ref_row), .dtack_n(dtack_n), .ref_miss(ref_miss)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe order: ras ucas lcas col we cdr cdw dae dtack
  localparam logic [8:0] IDLE_V  = 9'b1_1_1_0_1_1_1_1_1;
  localparam logic [8:0] ROW_V   = 9'b0_1_1_0_1_1_1_1_1;
  localparam logic [8:0] COLW_V  = 9'b0_1_1_1_1_1_1_1_1;
  localparam logic [8:0] RD_CAS  = 9'b0_0_0_1_1_0_1_1_1;
  localparam logic [8:0] RD_HOLD = 9'b0_0_0_1_1_0_1_1_0;
  localparam logic [8:0] BW_CAS  = 9'b0_1_0_1_0_1_0_1_1;
  localparam logic [8:0] BW_HOLD = 9'b0_1_0_1_0_1_0_1_0;
  localparam logic [8:0] WW_CAS  = 9'b0_0_0_1_0_1_0_1_1;
  localparam logic [8:0] WW_HOLD = 9'b0_0_0_1_0_1_0_1_0;
  localparam logic [8:0] WP_CAS  = 9'b0_1_1_1_1_1_1_1_1;
  localparam logic [8:0] WP_HOLD = 9'b0_1_1_1_1_1_1_1_0;
  localparam logic [8:0] REF_V   = 9'b0_1_1_0_1_1_1_0_1;
  localparam logic [17:0] M_ALL  = 18'h3FFFF;
  localparam logic [17:0] M_STB  = 18'h001FF;
  localparam logic [17:0] M_ROW  = 18'h1FE00;
  localparam logic [17:0] M_MISS = 18'h20000;

  logic [17:0] vec;
  assign vec = {ref_miss, ref_row, ras_n, ucas_n, lcas_n, col, we_n, cdr_n, cdw_n, dae_n, dtack_n};

  typedef struct {
    int          cyc;
    string       tag;
    logic [17:0] exp;
    logic [17:0] mask;
  } sb_entry_t;

  sb_entry_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic expect_at(input int c, input string tag, input logic [17:0] exp,
                           input logic [17:0] mask);
    sb_entry_t e;
    e.cyc  = c;
    e.tag  = tag;
    e.exp  = exp;
    e.mask = mask;
    sb.push_back(e);
  endtask

  task automatic exp_stb(input int c, input string tag, input logic [8:0] v);
    expect_at(c, tag, {9'h000, v}, M_STB);
  endtask

  task automatic exp_full(input int c, input string tag, input logic [8:0] v,
                          input logic [7:0] row, input logic miss);
    expect_at(c, tag, {miss, row, v}, M_ALL);
  endtask

  always @(negedge clk) begin : monitor
    sb_entry_t e;
    while (sb.size() != 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      $display("txn cyc=%0d %s vec=%h", cyc, e.tag, vec & e.mask);
      check_val(e.tag, 32'(vec & e.mask), 32'(e.exp & e.mask));
    end
  end

  task automatic wait_to(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic s, input logic a, input logic u, input logic l,
                       input logic p, input logic w);
    sel = s; as_n = a; uds_n = u; lds_n = l; prw_n = p; wpro = w;
  endtask

  int r0, w256, w258, s0;

  initial begin
    rst = 1'b1;
    drive(0, 1, 1, 1, 1, 0);
    repeat (3) @(posedge clk);
    #1;
    check_val("reset", 32'(vec), 32'({1'b0, 8'h00, IDLE_V}));
    rst = 1'b0;
    r0  = cyc;

    // Word read, then T_RP guard on the follow-up access, which is aborted before DTACK.
    wait_to(r0 + 2);
    drive(1, 0, 0, 0, 1, 0);
    exp_stb(r0 + 3, "rd_ras", ROW_V);
    exp_stb(r0 + 4, "rd_row_hold", ROW_V);
    exp_stb(r0 + 5, "rd_cas", RD_CAS);
    exp_stb(r0 + 6, "rd_cas2", RD_CAS);
    exp_stb(r0 + 7, "rd_dtack", RD_HOLD);
    exp_stb(r0 + 9, "rd_hold", RD_HOLD);
    wait_to(r0 + 9);
    drive(1, 1, 0, 0, 1, 0);
    exp_stb(r0 + 10, "rd_release", IDLE_V);
    wait_to(r0 + 10);
    drive(1, 0, 0, 0, 1, 0);
    exp_stb(r0 + 11, "rp_pre", IDLE_V);
    exp_stb(r0 + 12, "rp_idle", IDLE_V);
    exp_stb(r0 + 13, "rp_ras", ROW_V);
    wait_to(r0 + 13);
    drive(1, 1, 0, 0, 1, 0);
    exp_stb(r0 + 14, "abort", IDLE_V);
    exp_stb(r0 + 16, "abort_nodtack", IDLE_V);
    wait_to(r0 + 16);
    drive(0, 1, 1, 1, 1, 0);

    // Byte write with late _LDS.
    wait_to(r0 + 20);
    drive(1, 0, 1, 1, 0, 0);
    exp_stb(r0 + 21, "bw_ras", ROW_V);
    exp_stb(r0 + 23, "bw_colwait", COLW_V);
    exp_stb(r0 + 24, "bw_cas", BW_CAS);
    exp_stb(r0 + 25, "bw_cas2", BW_CAS);
    exp_stb(r0 + 26, "bw_dtack", BW_HOLD);
    wait_to(r0 + 22);
    lds_n = 1'b0;
    wait_to(r0 + 26);
    drive(0, 1, 1, 1, 1, 0);
    exp_stb(r0 + 27, "bw_release", IDLE_V);

    // Word write and read with WPRO asserted.
    wait_to(r0 + 35);
    drive(1, 0, 0, 0, 0, 1);
`ifdef DAUG_WPRO_EN
    exp_stb(r0 + 39, "wp_cas", WP_CAS);
    exp_stb(r0 + 41, "wp_dtack", WP_HOLD);
`else
    exp_stb(r0 + 39, "ww_cas", WW_CAS);
    exp_stb(r0 + 41, "ww_dtack", WW_HOLD);
`endif
    wait_to(r0 + 41);
    drive(0, 1, 1, 1, 1, 0);
    exp_stb(r0 + 42, "ww_release", IDLE_V);
    wait_to(r0 + 50);
    drive(1, 0, 0, 0, 1, 1);
    exp_stb(r0 + 53, "wp_rd_cas", RD_CAS);
    exp_stb(r0 + 55, "wp_rd_dtack", RD_HOLD);
    wait_to(r0 + 55);
    drive(0, 1, 1, 1, 1, 0);

    // Access request on the same edge as the first timer wrap.
    wait_to(r0 + 107);
    drive(1, 0, 0, 0, 1, 0);
    exp_full(r0 + 108, "col_rrow", REF_V, 8'h00, 1'b0);
    exp_full(r0 + 111, "col_rcas", REF_V, 8'h00, 1'b0);
    exp_full(r0 + 112, "col_pre_row", IDLE_V, 8'h01, 1'b0);
    exp_stb(r0 + 114, "col_idle", IDLE_V);
    exp_stb(r0 + 115, "col_ras", ROW_V);
    exp_stb(r0 + 117, "col_cas", RD_CAS);
    exp_stb(r0 + 119, "col_dtack", RD_HOLD);
    wait_to(r0 + 120);
    drive(0, 1, 1, 1, 1, 0);
    exp_stb(r0 + 121, "col_release", IDLE_V);

    // Row counter wrap on the 256th refresh, then a held read spanning two ticks.
    w256 = r0 + 108 * 256;
    w258 = w256 + 216;
    exp_stb(w256, "ref256_rrow", REF_V);
    expect_at(w256 + 3, "row_ff", {1'b0, 8'hFF, 9'h000}, M_ROW);
    expect_at(w256 + 4, "row_wrap", {1'b0, 8'h00, 9'h000}, M_ROW);
    wait_to(w256 + 10);
    drive(1, 0, 0, 0, 1, 0);
    exp_stb(w256 + 15, "miss_rd_dtack", RD_HOLD);
    expect_at(w258 - 1, "miss_before", 18'h00000, M_MISS);
    expect_at(w258, "miss_set", M_MISS, M_MISS);
    wait_to(w258 + 1);
    drive(0, 1, 1, 1, 1, 0);
    exp_stb(w258 + 2, "miss_release", IDLE_V);
    exp_stb(w258 + 5, "miss_refresh", REF_V);
    expect_at(w258 + 9, "miss_row", {1'b0, 8'h01, 9'h000}, M_ROW);

    // Reset in the middle of a write.
    s0 = w258 + 20;
    wait_to(s0);
    drive(1, 0, 0, 0, 0, 0);
    exp_stb(s0 + 4, "rst_ww_cas", WW_CAS);
    exp_full(s0 + 5, "rst_mid", IDLE_V, 8'h00, 1'b0);
    wait_to(s0 + 4);
    rst = 1'b1;
    wait_to(s0 + 5);
    rst = 1'b0;
    drive(0, 1, 1, 1, 1, 0);
    exp_full(s0 + 6, "rst_after", IDLE_V, 8'h00, 1'b0);

    wait_to(s0 + 8);
    check_val("sb_drain", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
